// File: rtl/prog_load_sequencer.sv
// rtl/prog_load_sequencer.sv - streams a program image into ROM, then runs the CPU until halt or timeout
// Every output is a register; state transitions set the outputs that the next state presents.
module prog_load_sequencer #(
  parameter int ROM_DEPTH    = 256,
  parameter int HALT_REPEATS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [7:0]  cmd_base,
  input  logic [15:0] max_cycles,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        rom_we,
  output logic [7:0]  rom_addr,
  output logic [7:0]  rom_wdata,
  output logic        cpu_run,
  output logic        pc_load,
  output logic [7:0]  pc_value,
  input  logic        ifetch,
  input  logic [7:0]  cpu_pc,
  output logic        busy,
  output logic        done,
  output logic        halted,
  output logic        timeout,
  output logic        overflow,
  output logic [8:0]  byte_count,
  output logic [15:0] run_cycles
);

  localparam int RW = $clog2(HALT_REPEATS + 1);
  localparam logic [RW-1:0] HALT_N = RW'(HALT_REPEATS);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} state_t;

  state_t        state;
  logic [7:0]    base;
  logic [7:0]    addr;
  logic [15:0]   max_cyc;
  logic [7:0]    prev_pc;
  logic          have_prev;
  logic [RW-1:0] rep;

  logic          hs;
  logic [15:0]   run_next;
  logic [RW-1:0] rep_next;
  logic          halt_hit;
  logic          time_hit;

  always_comb begin
    hs       = s_valid & s_ready;
    run_next = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
    // The first fetch of a run has no predecessor, so it never counts as a repeat.
    rep_next = (have_prev && (cpu_pc == prev_pc)) ? rep + RW'(1) : '0;
    halt_hit = ifetch && (rep_next == HALT_N);
    time_hit = (max_cyc != 16'd0) && (run_next == max_cyc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      addr       <= '0;
      max_cyc    <= '0;
      prev_pc    <= '0;
      have_prev  <= 1'b0;
      rep        <= '0;
      s_ready    <= 1'b0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      cpu_run    <= 1'b0;
      pc_load    <= 1'b0;
      pc_value   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
      run_cycles <= '0;
    end else begin
      rom_we  <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (cmd_start) begin
            state      <= LOAD;
            base       <= cmd_base;
            addr       <= cmd_base;
            max_cyc    <= max_cycles;
            byte_count <= '0;
            run_cycles <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            s_ready    <= 1'b1;
            cpu_run    <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            rom_we     <= 1'b1;
            rom_addr   <= addr;
            rom_wdata  <= s_data;
            addr       <= addr + 8'd1;
            byte_count <= byte_count + 9'd1;
            if (s_last) begin
              state    <= ARM;
              s_ready  <= 1'b0;
              pc_load  <= 1'b1;
              pc_value <= base;
            end else if (byte_count == 9'(ROM_DEPTH - 1)) begin
              // Image filled the ROM without a last marker: the CPU is never released.
              state    <= DONE;
              s_ready  <= 1'b0;
              overflow <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        ARM: begin
          state     <= RUN;
          cpu_run   <= 1'b1;
          have_prev <= 1'b0;
          rep       <= '0;
        end
        RUN: begin
          run_cycles <= run_next;
          if (ifetch) begin
            prev_pc   <= cpu_pc;
            have_prev <= 1'b1;
            rep       <= rep_next;
          end
          if (halt_hit || time_hit) begin
            state   <= DONE;
            cpu_run <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            halted  <= halt_hit;
            timeout <= ~halt_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_sequencer.sv
// tb/tb_prog_load_sequencer.sv - table-driven sessions with a ROM-write scoreboard
module tb_prog_load_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [7:0]  cmd_base;
  logic [15:0] max_cycles;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        rom_we;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_wdata;
  logic        cpu_run;
  logic        pc_load;
  logic [7:0]  pc_value;
  logic        ifetch;
  logic [7:0]  cpu_pc;
  logic        busy;
  logic        done;
  logic        halted;
  logic        timeout;
  logic        overflow;
  logic [8:0]  byte_count;
  logic [15:0] run_cycles;

  prog_load_sequencer dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_base(cmd_base),
    .max_cycles(max_cycles), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_run(cpu_run), .pc_load(pc_load), .pc_value(pc_value), .ifetch(ifetch),
    .cpu_pc(cpu_pc), .busy(busy), .done(done), .halted(halted), .timeout(timeout),
    .overflow(overflow), .byte_count(byte_count), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         due;
  } wr_t;

  typedef struct {
    logic [7:0]  base;
    int          len;
    logic        last;
    logic [15:0] maxc;
    int          mode;   // 0: fetch PCs 0,2,2,2..  1: never repeat
    int          gap;    // random s_valid gaps
    int          poke;   // pulse cmd_start mid-run
    logic        e_halt;
    logic        e_to;
    logic        e_ovf;
    int          e_bytes;
    int          e_run;
    int          e_pcl;
  } vec_t;

  wr_t        sb[$];
  vec_t       vecs[8];
  logic [7:0] pat[4];
  logic [7:0] img0[4];
  int n_cmp = 0;
  int n_bad = 0;
  int ncyc = 0;
  int n_run, n_pcl, t_cnt, t_pcl, t_run1, k_fetch, cur_mode;
  logic [7:0] pcv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    ncyc++;
    if (rom_we === 1'b1) begin
      chk("rom_we_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rom_addr", 32'(rom_addr), 32'(e.addr));
        chk("rom_wdata", 32'(rom_wdata), 32'(e.data));
        chk("rom_write_cycle", 32'(ncyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    if (cpu_run) begin
      ifetch = 1'b1;
      cpu_pc = (cur_mode == 0) ? pat[(k_fetch > 3) ? 3 : k_fetch] : 8'(k_fetch);
      k_fetch++;
    end else begin
      ifetch = 1'b0;
      cpu_pc = 8'h00;
    end
    @(posedge clk);
    #1;
    t_cnt++;
    if (pc_load) begin
      n_pcl++;
      pcv   = pc_value;
      t_pcl = t_cnt;
    end
    if (cpu_run) begin
      if (n_run == 0) t_run1 = t_cnt;
      n_run++;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {18'd0, busy, done, halted, timeout, overflow, s_ready, rom_we, cpu_run, pc_load,
               rom_addr, rom_wdata, pc_value}, 32'd0);
    chk({name, "_counts"}, {7'd0, byte_count, run_cycles}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int i, guard;
    bit poked;
    cur_mode = v.mode; k_fetch = 0; n_run = 0; n_pcl = 0;
    t_pcl = -1; t_run1 = -1; t_cnt = 0; pcv = 8'h00; poked = 0;
    cmd_start = 1'b1; cmd_base = v.base; max_cycles = v.maxc;
    tick();
    cmd_start = 1'b0; cmd_base = 8'hA5; max_cycles = 16'hFFFF;
    chk($sformatf("v%0d_start_busy_ready_done", idx), {29'd0, busy, s_ready, done}, 32'd6);
    chk($sformatf("v%0d_start_cleared", idx),
        {4'd0, byte_count, run_cycles, halted, timeout, overflow}, 32'd0);
    i = 0; guard = 0;
    while (i < v.len && guard < 4 * v.len + 50) begin
      s_valid = v.gap != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = (idx == 0) ? img0[i] : 8'($urandom);
      s_last  = v.last && (i == v.len - 1);
      if (s_valid && s_ready) begin
        sb.push_back('{addr: v.base + 8'(i), data: s_data, due: ncyc + 2});
        i++;
      end
      tick();
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk($sformatf("v%0d_stream_taken", idx), 32'(i), 32'(v.len));
    guard = 0;
    while (!done && guard < 400) begin
      if (v.poke != 0 && n_run == 10 && !poked) begin
        cmd_start = 1'b1; cmd_base = 8'h99; max_cycles = 16'd3; poked = 1;
      end
      tick();
      cmd_start = 1'b0;
      guard++;
    end
    chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_flags_h_t_o", idx), {29'd0, halted, timeout, overflow},
        {29'd0, v.e_halt, v.e_to, v.e_ovf});
    chk($sformatf("v%0d_busy_run_low", idx), {30'd0, busy, cpu_run}, 32'd0);
    chk($sformatf("v%0d_byte_count", idx), 32'(byte_count), 32'(v.e_bytes));
    chk($sformatf("v%0d_run_cycles", idx), 32'(run_cycles), 32'(v.e_run));
    chk($sformatf("v%0d_cpu_run_cycles", idx), 32'(n_run), 32'(v.e_run));
    chk($sformatf("v%0d_pc_load_count", idx), 32'(n_pcl), 32'(v.e_pcl));
    if (v.e_pcl != 0) begin
      chk($sformatf("v%0d_pc_value", idx), 32'(pcv), 32'(v.base));
      chk($sformatf("v%0d_run_after_pcload", idx), 32'(t_run1), 32'(t_pcl + 1));
    end
    tick();
    tick();
    chk($sformatf("v%0d_scoreboard_drained", idx), 32'(sb.size()), 32'd0);
    chk($sformatf("v%0d_done_hold", idx), {22'd0, done, byte_count}, {22'd0, 1'b1, 9'(v.e_bytes)});
  endtask

  initial begin
    pat[0] = 8'h00; pat[1] = 8'h02; pat[2] = 8'h02; pat[3] = 8'h02;
    img0[0] = 8'h10; img0[1] = 8'h05; img0[2] = 8'h20; img0[3] = 8'hFE;
    //          base   len  last  max     md gp pk  halt  to    ovf   bytes run pcl
    vecs[0] = '{8'h00, 4,   1'b1, 16'd0,   0, 0, 0, 1'b1, 1'b0, 1'b0, 4,   4,   1};
    vecs[1] = '{8'hFE, 3,   1'b1, 16'd0,   0, 1, 0, 1'b1, 1'b0, 1'b0, 3,   4,   1};
    vecs[2] = '{8'h40, 256, 1'b0, 16'd0,   0, 0, 0, 1'b0, 1'b0, 1'b1, 256, 0,   0};
    vecs[3] = '{8'h10, 5,   1'b1, 16'd100, 1, 1, 0, 1'b0, 1'b1, 1'b0, 5,   100, 1};
    vecs[4] = '{8'h80, 2,   1'b1, 16'd4,   0, 0, 0, 1'b1, 1'b0, 1'b0, 2,   4,   1};
    vecs[5] = '{8'h00, 256, 1'b1, 16'd0,   0, 1, 0, 1'b1, 1'b0, 1'b0, 256, 4,   1};
    vecs[6] = '{8'h55, 1,   1'b1, 16'd1,   1, 0, 0, 1'b0, 1'b1, 1'b0, 1,   1,   1};
    vecs[7] = '{8'h30, 2,   1'b1, 16'd50,  1, 0, 1, 1'b0, 1'b1, 1'b0, 2,   50,  1};

    reset = 1'b1; cmd_start = 1'b0; cmd_base = 8'h00; max_cycles = 16'd0;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; ifetch = 1'b0; cpu_pc = 8'h00;
    cur_mode = 0; k_fetch = 0; n_run = 0; n_pcl = 0; t_cnt = 0; t_pcl = -1; t_run1 = -1;
    pcv = 8'h00;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk_all_zero("reset_state");

    // Reset lands mid-load while a byte is offered: that byte must never be written.
    cmd_start = 1'b1; cmd_base = 8'h20; max_cycles = 16'd0;
    tick();
    cmd_start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      s_valid = 1'b1; s_data = 8'(8'hC0 + j); s_last = 1'b0;
      if (s_ready) sb.push_back('{addr: 8'(8'h20 + j), data: s_data, due: ncyc + 2});
      tick();
    end
    s_data = 8'h77; reset = 1'b1;
    tick();
    chk_all_zero("reset_mid_load");
    reset = 1'b0;
    for (int j = 0; j < 3; j++) tick();
    s_valid = 1'b0;
    chk("reset_mid_load_idle", {30'd0, busy, s_ready}, 32'd0);
    chk("reset_mid_load_writes", 32'(sb.size()), 32'd0);

    for (int j = 0; j < 8; j++) run_vec(vecs[j], j);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
